// File: rtl/char_fifo_serial.sv
// Character FIFO fed by an asynchronous write strobe (sign) and drained by a
// synchronous pop; tracks occupancy and a sticky overflow flag.
module char_fifo_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sign,
  input  logic [WIDTH-1:0] dato,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] datoEstable,
  output logic             vacio,
  output logic             lleno,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic             s1, s2, s3;
  logic             wr, pop, full, empty, do_wr, drop;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] mem [DEPTH];

  // Rising edge of the synchronized strobe is one write request.
  always_comb begin
    wr         = s2 & ~s3;
    full       = (count == CW'(DEPTH));
    empty      = (count == CW'(0));
    pop        = rd_en & ~empty;
    do_wr      = wr & (~full | pop);
    drop       = wr & full & ~pop;
    count_next = count;
    case ({do_wr, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      datoEstable <= '0;
      overflow    <= 1'b0;
      vacio       <= 1'b1;
      lleno       <= 1'b0;
    end else begin
      s1 <= sign;
      s2 <= s1;
      s3 <= s2;
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        datoEstable <= mem[rd_ptr];
      end
      count <= count_next;
      vacio <= (count_next == CW'(0));
      lleno <= (count_next == CW'(DEPTH));
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: entries outside rd_ptr..wr_ptr are never read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= dato;
  end

endmodule

// File: tb/tb_char_fifo_serial.sv
// Bench for char_fifo_serial: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_char_fifo_serial;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             sign;
  logic [WIDTH-1:0] dato;
  logic             rd_en;
  logic             clr_ovf;
  logic [WIDTH-1:0] datoEstable;
  logic             vacio, lleno, overflow;
  logic [CW-1:0]    count;

  char_fifo_serial #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .sign(sign), .dato(dato), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .datoEstable(datoEstable), .vacio(vacio),
    .lleno(lleno), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_last;
  bit               m_ovf;
  bit               samp1, samp2, samp3;   // sign sampled 1, 2, 3 edges ago
  int               vectors = 0;
  int               miscompares = 0;

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    samp1  = 1'b0;
    samp2  = 1'b0;
    samp3  = 1'b0;
  endtask

  // A character is written when sign was first seen high two edges earlier.
  task automatic model_edge();
    bit wr, pop;
    wr  = samp2 && !samp3;
    pop = rd_en && (q.size() > 0);
    if (pop) m_last = q.pop_front();
    if (wr) begin
      if (q.size() < DEPTH) q.push_back(dato);
      else m_ovf = 1'b1;
    end
    if (!(wr && !pop && q.size() == DEPTH && !(pop)) || !wr) begin
      if (clr_ovf && !(wr && q.size() == DEPTH && !pop && m_ovf)) m_ovf = 1'b0;
    end
    samp3 = samp2;
    samp2 = samp1;
    samp1 = sign;
  endtask

  task automatic check(input string tag);
    logic [CW-1:0] ec;
    ec = CW'(q.size());
    vectors++;
    assert (count === ec) else begin
      miscompares++;
      $error("FAIL %s count got %0d exp %0d", tag, count, ec);
    end
    vectors++;
    assert (vacio === (q.size() == 0)) else begin
      miscompares++;
      $error("FAIL %s vacio got %b exp %b", tag, vacio, q.size() == 0);
    end
    vectors++;
    assert (lleno === (q.size() == DEPTH)) else begin
      miscompares++;
      $error("FAIL %s lleno got %b exp %b", tag, lleno, q.size() == DEPTH);
    end
    vectors++;
    assert (overflow === m_ovf) else begin
      miscompares++;
      $error("FAIL %s overflow got %b exp %b", tag, overflow, m_ovf);
    end
    vectors++;
    assert (datoEstable === m_last) else begin
      miscompares++;
      $error("FAIL %s datoEstable got %h exp %h", tag, datoEstable, m_last);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check 1 ns later.
  task automatic step(input logic s, input logic [WIDTH-1:0] d,
                      input logic r, input logic c, input string tag);
    sign = s; dato = d; rd_en = r; clr_ovf = c;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  // Two-cycle strobe; the write lands on the third step, where r is applied.
  task automatic put(input logic [WIDTH-1:0] d, input logic r, input string tag);
    step(1'b1, d, 1'b0, 1'b0, tag);
    step(1'b1, d, 1'b0, 1'b0, tag);
    step(1'b0, d, r,    1'b0, tag);
    step(1'b0, d, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [WIDTH-1:0] got;
  logic             rs;

  initial begin
    reset = 1'b1; sign = 1'b0; dato = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #1;
    check("reset_init");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single character with latency observation
    step(1'b1, 8'h41, 1'b0, 1'b0, "single_e0");
    step(1'b1, 8'h41, 1'b0, 1'b0, "single_e1");
    step(1'b1, 8'h41, 1'b0, 1'b0, "single_e2");
    vectors++;
    assert (vacio === 1'b0) else begin
      miscompares++;
      $error("FAIL single_latency vacio got %b exp 0", vacio);
    end
    step(1'b0, 8'h41, 1'b0, 1'b0, "single_idle");
    step(1'b0, 8'h41, 1'b0, 1'b0, "single_idle");
    step(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
    vectors++;
    assert (datoEstable === 8'h41) else begin
      miscompares++;
      $error("FAIL single_data datoEstable got %h exp 41", datoEstable);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, "empty_pop_ignored");

    // Fill, partial drain, wrap
    for (int i = 0; i < 16; i++) put(WIDTH'(i), 1'b0, "fill");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "pop4");
    for (int i = 16; i < 20; i++) put(WIDTH'(i), 1'b0, "wrap_fill");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, "pop16");
      got = datoEstable;
      vectors++;
      assert (got === WIDTH'(i + 4)) else begin
        miscompares++;
        $error("FAIL wrap_order datoEstable got %h exp %h", got, WIDTH'(i + 4));
      end
    end

    // Overflow on full, then clear
    for (int i = 0; i < 16; i++) put(WIDTH'(8'h30 + i), 1'b0, "refill");
    put(8'hAA, 1'b0, "overflow");
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

    // Write and pop together while full, then write with rd_en while empty
    put(8'h55, 1'b1, "full_simul");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      vectors++;
      assert (datoEstable !== 8'hAA) else begin
        miscompares++;
        $error("FAIL dropped_char datoEstable got %h exp not aa", datoEstable);
      end
    end
    put(8'h66, 1'b1, "empty_simul");

    // Held strobe yields a single write
    for (int i = 0; i < 20; i++) step(1'b1, 8'h77, 1'b0, 1'b0, "held");
    step(1'b0, 8'h77, 1'b0, 1'b0, "held_end");

    // Mid-operation reset with a write in the synchronizer
    for (int i = 0; i < 3; i++) put(WIDTH'(8'h80 + i), 1'b0, "pre_reset");
    step(1'b1, 8'h99, 1'b0, 1'b0, "inflight");
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h99, 1'b0, 1'b0, "post_reset");

    // Strobe held high across reset release
    sign = 1'b1;
    do_reset("reset_held_sign");
    for (int i = 0; i < 4; i++) step(1'b1, 8'h5A, 1'b0, 1'b0, "release_write");
    step(1'b0, 8'h5A, 1'b0, 1'b0, "release_done");

    // Random traffic
    rs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) rs = ~rs;
      step(rs, WIDTH'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_fifo_serial.md
CHAR_FIFO_SERIAL -- requirements
Module: char_fifo_serial

Interface
REQ-001 Parameter WIDTH, default 8, character width in bits (1..32).
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; a power of two, 2..256.
REQ-003 Parameter CW, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 Port clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port sign  input  1  character strobe, asynchronous to clk; each rising edge writes one character.
REQ-007 Port dato  input  WIDTH  character data; stable from the sign rise until 3 clk cycles after it.
REQ-008 Port rd_en  input  1  pop request, synchronous to clk.
REQ-009 Port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-010 Port datoEstable  output  WIDTH  registered last-popped character.
REQ-011 Port vacio  output  1  high when the FIFO is empty.
REQ-012 Port lleno  output  1  high when the FIFO holds DEPTH entries.
REQ-013 Port overflow  output  1  sticky flag for a character dropped on a full FIFO.
REQ-014 Port count  output  CW  current occupancy, 0..DEPTH.

Function
REQ-015 sign SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3; write strobe wr = s2 & ~s3.
REQ-016 sign high first sampled at edge n SHALL give wr high during cycle n+2, with the write taken at edge n+2; the character is visible (vacio=0) after edge n+2.
REQ-017 A sign level held high SHALL produce exactly one write; a new write requires sign low for at least 2 clk cycles.
REQ-018 On a write, dato SHALL be sampled at the write edge and stored at wr_ptr; wr_ptr then increments modulo DEPTH.
REQ-019 A pop (rd_en=1 and vacio=0) SHALL load datoEstable with mem[rd_ptr] at that edge; rd_ptr then increments modulo DEPTH; pop-to-data latency is 1 cycle.
REQ-020 datoEstable SHALL hold its value in every cycle with no pop.
REQ-021 rd_en while empty SHALL be ignored: no pointer change, datoEstable unchanged, no error flag.
REQ-022 A write while full without a simultaneous pop SHALL be dropped: memory and pointers unchanged, and overflow set to 1 at that edge.
REQ-023 A write and a pop in the same cycle while full SHALL both complete; count stays at DEPTH, overflow unchanged.
REQ-024 A write and rd_en in the same cycle while empty SHALL perform the write only; count becomes 1.
REQ-025 A write and a pop in the same cycle with 0<count<DEPTH SHALL both complete; count unchanged.
REQ-026 count SHALL change as follows: +1 on write-only, -1 on pop-only, 0 otherwise.
REQ-027 vacio SHALL equal (count==0) and lleno SHALL equal (count==DEPTH), both registered-consistent with count.
REQ-028 clr_ovf SHALL clear overflow at the next edge; if a drop occurs in the same cycle, overflow SHALL end at 1 (set wins).
REQ-029 Pointers SHALL be log2(DEPTH) bits wide; wrap-around is natural modulo DEPTH and needs no special case.

Reset
REQ-030 reset=1 SHALL immediately force s1=s2=s3=0, wr_ptr=rd_ptr=0, count=0, datoEstable=0, overflow=0, vacio=1, lleno=0.
REQ-031 Memory contents SHALL NOT require reset; after reset, stale entries are unreachable.
REQ-032 Reset asserted mid-operation SHALL discard all stored characters and any write in flight in the synchronizer.
REQ-033 sign held high through reset release SHALL produce one write, 2 edges after the first edge with reset low.

Verification
REQ-034 Single char: after reset, sign pulse 3 cycles with dato=8'h41 -> vacio falls 2 edges after the first sampling edge; rd_en 1 cycle -> next cycle datoEstable=8'h41, vacio=1, count=0.
REQ-035 Fill/wrap: DEPTH=16, write 8'h00..8'h0F -> lleno=1, count=16; pop 4, write 8'h10..8'h13, pop 16 -> sequence 8'h00..8'h13 in order.
REQ-036 Overflow: on full, write 8'hAA -> overflow=1, count=16, 8'hAA never popped; clr_ovf 1 cycle -> overflow=0.
REQ-037 Simultaneous: when full, write coincides with pop -> count stays 16, overflow stays 0; when empty, write coincides with rd_en -> count=1, datoEstable unchanged.
REQ-038 Held strobe: sign high 20 cycles -> exactly one write, count=1.
REQ-039 Mid-reset: with count=5 and a write in the synchronizer, pulse reset -> all outputs at reset values, and the pending write is lost.
